// File: rtl/dms_fir_filt_mc.sv
// Time-multiplexed multi-channel FIR filter with a shared real coefficient bank,
// per-channel decimation, output saturation and a pass-through bypass mode.
module dms_fir_filt_mc #(
  parameter int  N_TAPS    = 8,
  parameter int  N_CH      = 2,
  parameter int  DECIM     = 1,
  parameter real OUT_LIMIT = 1.0e3,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  real           in_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  real           coef_data,
  input  logic          bypass,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output real           out_sample,
  output logic          out_sat
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  real           taps   [N_CH][N_TAPS];
  real           coef   [N_TAPS];
  logic [DW-1:0] decCnt [N_CH];

  logic          accept;
  logic [CW-1:0] chIdx;
  logic          fire;
  logic          coefOk;
  real           newTaps [N_TAPS];
  real           acc;
  real           result;
  real           satVal;
  logic          satFlag;

  // Result is formed from the delay line as it will look after this sample
  // shifts in, using the coefficients as they are before any coincident write.
  always_comb begin
    accept = in_valid && (32'(in_ch) < N_CH);
    chIdx  = accept ? in_ch : '0;
    coefOk = coef_we && (32'(coef_addr) < N_TAPS);
    newTaps[0] = in_sample;
    for (int k = 1; k < N_TAPS; k++) newTaps[k] = taps[chIdx][k-1];
    acc = 0.0;
    for (int k = 0; k < N_TAPS; k++) acc = acc + coef[k] * newTaps[k];
    fire    = bypass || (decCnt[chIdx] == DW'(DECIM - 1));
    result  = bypass ? in_sample : acc;
    satFlag = 1'b0;
    satVal  = result;
    if (result > OUT_LIMIT) begin
      satVal  = OUT_LIMIT;
      satFlag = 1'b1;
    end else if (result < -OUT_LIMIT) begin
      satVal  = -OUT_LIMIT;
      satFlag = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < N_TAPS; k++) taps[c][k] <= 0.0;
        decCnt[c] <= '0;
      end
      for (int k = 0; k < N_TAPS; k++) coef[k] <= 1.0 / N_TAPS;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= 0.0;
      out_sat    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        for (int k = 0; k < N_TAPS; k++) taps[chIdx][k] <= newTaps[k];
        // Bypass pins the phase so filtering resumes at a fresh decimation cycle.
        if (fire) decCnt[chIdx] <= '0;
        else      decCnt[chIdx] <= decCnt[chIdx] + 1'b1;
        if (fire) begin
          out_valid  <= 1'b1;
          out_ch     <= in_ch;
          out_sample <= satVal;
          out_sat    <= satFlag;
        end
      end
      if (coefOk) coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_dms_fir_filt_mc.sv
// Randomized bench for dms_fir_filt_mc: a sample-log reference model predicts every
// output cycle, and a few directed sequences pin the model to hand-worked values.
module tb_dms_fir_filt_mc;

  localparam int  N_TAPS = 5;
  localparam int  N_CH   = 3;
  localparam int  DECIM  = 2;
  localparam real LIM    = 1.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_ch = '0;
  real        in_sample = 0.0;
  logic       coef_we = 1'b0;
  logic [2:0] coef_addr = '0;
  real        coef_data = 0.0;
  logic       bypass = 1'b0;
  logic       out_valid;
  logic [1:0] out_ch;
  real        out_sample;
  logic       out_sat;

  int checks = 0;
  int errors = 0;

  // Model state: every accepted sample since reset, plus per-channel sample counts.
  int   logCh [$];
  real  logVal [$];
  int   nAcc [N_CH];
  real  mCoef [N_TAPS];
  logic expValid;
  int   expCh;
  real  expSample;
  logic expSat;

  dms_fir_filt_mc #(.N_TAPS(N_TAPS), .N_CH(N_CH), .DECIM(DECIM), .OUT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .bypass(bypass),
    .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic bit near(real a, real b);
    return (a - b < 1.0e-9) && (b - a < 1.0e-9);
  endfunction

  task automatic modelReset();
    logCh.delete();
    logVal.delete();
    for (int c = 0; c < N_CH; c++) nAcc[c] = 0;
    for (int k = 0; k < N_TAPS; k++) mCoef[k] = 1.0 / N_TAPS;
    expValid = 1'b0;
    expCh = 0;
    expSample = 0.0;
    expSat = 1'b0;
  endtask

  // Weighted sum of the newest N_TAPS samples of a channel, newest weighted by coef[0].
  function automatic real filt(int ch);
    real s = 0.0;
    int found = 0;
    for (int i = logCh.size() - 1; i >= 0 && found < N_TAPS; i--) begin
      if (logCh[i] == ch) begin
        s += mCoef[found] * logVal[i];
        found++;
      end
    end
    return s;
  endfunction

  task automatic modelStep();
    real v;
    bit produce;
    int ch;
    produce = 1'b0;
    v = 0.0;
    ch = int'(in_ch);
    if (rst) begin
      modelReset();
      return;
    end
    if (in_valid && ch < N_CH) begin
      logCh.push_back(ch);
      logVal.push_back(in_sample);
      if (bypass) begin
        nAcc[ch] = 0;
        produce = 1'b1;
        v = in_sample;
      end else begin
        nAcc[ch]++;
        if (nAcc[ch] % DECIM == 0) begin
          produce = 1'b1;
          v = filt(ch);
        end
      end
    end
    expValid = produce;
    if (produce) begin
      expCh = ch;
      expSat = (v > LIM) || (v < -LIM);
      expSample = (v > LIM) ? LIM : ((v < -LIM) ? -LIM : v);
    end
    if (coef_we && int'(coef_addr) < N_TAPS) mCoef[coef_addr] = coef_data;
  endtask

  task automatic checkBit(string name, logic got, logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0b want %0b at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkReal(string name, real got, real want);
    checks++;
    if (!near(got, want)) begin
      errors++;
      $display("[TB] FAIL %s: got %f want %f at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    checkBit("out_valid", out_valid, expValid);
    checks++;
    if (int'(out_ch) != expCh) begin
      errors++;
      $display("[TB] FAIL out_ch: got %0d want %0d at %0t", out_ch, expCh, $time);
    end
    checkReal("out_sample", out_sample, expSample);
    checkBit("out_sat", out_sat, expSat);
  endtask

  task automatic applyStimulus(logic r, logic v, int ch, real s, logic we, int a, real d, logic byp);
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_ch = 2'(ch);
    in_sample = s;
    coef_we = we;
    coef_addr = 3'(a);
    coef_data = d;
    bypass = byp;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #1;
    modelReset();
    checkBit("reset out_valid", out_valid, 1'b0);
    checkReal("reset out_sample", out_sample, 0.0);
    checkBit("reset out_sat", out_sat, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse on ch0 with decimation by two: strobes after samples 2, 4, 6.
    applyStimulus(0, 1, 0, 1.0, 0, 0, 0.0, 0);
    checkBit("impulse s1 no strobe", out_valid, 1'b0);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    checkReal("impulse s2", out_sample, 0.2);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    checkReal("impulse s4", out_sample, 0.2);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    checkReal("impulse s6", out_sample, 0.0);
    checkBit("impulse s6 strobe", out_valid, 1'b1);

    applyStimulus(0, 1, 3, 5.0, 0, 0, 0.0, 0);
    checkBit("bad channel ignored", out_valid, 1'b0);

    // Coincident coefficient write only affects the following samples.
    applyStimulus(0, 1, 1, 1.0, 0, 0, 0.0, 0);
    applyStimulus(0, 1, 1, 1.0, 1, 0, 2.0, 0);
    checkReal("coef pre-write", out_sample, 0.4);
    applyStimulus(0, 1, 1, 1.0, 0, 0, 0.0, 0);
    applyStimulus(0, 1, 1, 1.0, 0, 0, 0.0, 0);
    checkReal("coef post-write clamp", out_sample, 1.0);
    checkBit("coef post-write sat", out_sat, 1'b1);

    applyStimulus(0, 1, 2, 0.7, 0, 0, 0.0, 1);
    checkReal("bypass value", out_sample, 0.7);
    applyStimulus(0, 1, 2, -1.5, 0, 0, 0.0, 1);
    checkReal("bypass neg clamp", out_sample, -1.0);
    checkBit("bypass neg sat", out_sat, 1'b1);

    // Reset raised between edges while a sample is pending.
    applyStimulus(0, 1, 0, 0.3, 0, 0, 0.0, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch = 2'd0;
    in_sample = 0.9;
    #2;
    rst = 1'b1;
    #1;
    checkBit("async reset valid", out_valid, 1'b0);
    checkReal("async reset sample", out_sample, 0.0);
    @(posedge clk);
    #1;
    checkBit("no strobe under reset", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    modelReset();
    applyStimulus(0, 1, 0, 1.0, 0, 0, 0.0, 0);
    applyStimulus(0, 1, 0, 0.0, 0, 0, 0.0, 0);
    checkReal("post-reset impulse", out_sample, 0.2);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(
        ($urandom_range(0, 99) == 0),
        ($urandom_range(0, 3) != 0),
        $urandom_range(0, 3),
        (real'($urandom_range(0, 4000)) - 2000.0) / 1000.0,
        ($urandom_range(0, 9) == 0),
        $urandom_range(0, 7),
        (real'($urandom_range(0, 2000)) - 1000.0) / 1000.0,
        ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dms_fir_filt_mc.md
DMS_FIR_FILT_MC -- requirements
Module: dms_fir_filt_mc

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, number of FIR taps per channel (>=2).
REQ-002 SHALL have parameter N_CH, default 2, number of time-multiplexed channels (>=1).
REQ-003 SHALL have parameter DECIM, default 1, output decimation factor per channel (>=1).
REQ-004 SHALL have parameter OUT_LIMIT, default 1.0e3 (real), symmetric output saturation magnitude.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports in order follow.
REQ-006 clk  input  1  sample clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  in_sample/in_ch qualified this cycle.
REQ-009 in_ch  input  max(1,$clog2(N_CH))  channel index of incoming sample.
REQ-010 in_sample  input  real  incoming sample value.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  max(1,$clog2(N_TAPS))  tap index to write.
REQ-013 coef_data  input  real  coefficient value.
REQ-014 bypass  input  1  1 = pass samples straight through, no filtering or decimation.
REQ-015 out_valid  output  1  single-cycle strobe, output result valid.
REQ-016 out_ch  output  max(1,$clog2(N_CH))  channel of current result.
REQ-017 out_sample  output  real  filtered (or bypassed) value, held between strobes.
REQ-018 out_sat  output  1  result on this strobe was clamped; held with out_sample.

Function
REQ-019 SHALL keep one N_TAPS-deep real delay line and one decimation counter per channel; a coefficient bank of N_TAPS reals shared by all channels.
REQ-020 On in_valid with in_ch < N_CH: shift that channel's delay line (tap0 = in_sample, tap k = old tap k-1, oldest dropped); other channels untouched.
REQ-021 in_valid with in_ch >= N_CH: sample ignored, no state change, no out_valid.
REQ-022 Filtered result = sum over k of coef[k]*tap[k], using the delay line after the REQ-020 shift.
REQ-023 Decimation: counter increments per accepted sample; when counter == DECIM-1 it wraps to 0 and an output is produced; otherwise no output.
REQ-024 Latency: out_valid asserts exactly one clk after the accepting edge; out_ch = accepting in_ch; back-to-back samples give back-to-back strobes.
REQ-025 Saturation: result > OUT_LIMIT -> OUT_LIMIT, < -OUT_LIMIT -> -OUT_LIMIT, out_sat=1; else out_sat=0.
REQ-026 bypass=1: every accepted sample produces out_sample = in_sample (saturated per REQ-025), latency 1; delay line still shifts; that channel's decimation counter forced to 0.
REQ-027 coef_we with coef_addr < N_TAPS writes coef_data at clk edge; coef_addr >= N_TAPS ignored.
REQ-028 Coefficient write coincident with accepted sample: that sample's result uses pre-write coefficients; new value applies from next sample.
REQ-029 out_sample/out_ch/out_sat hold last values when out_valid=0.

Reset
REQ-030 rst=1 SHALL immediately (no clk needed) clear all delay lines to 0.0, decimation counters to 0, coef[k] to 1.0/N_TAPS, out_valid to 0, out_ch to 0, out_sample to 0.0, out_sat to 0.
REQ-031 Reset asserted mid-stream SHALL abort any pending output strobe; first post-reset result uses only post-reset samples.
REQ-032 in_valid and coef_we SHALL be ignored while rst=1.

Verification
REQ-033 N_TAPS=4,N_CH=1,DECIM=1, default coefs: impulse 1.0 then zeros -> out_sample 0.25,0.25,0.25,0.25,0.0, each one clk after its input.
REQ-034 N_CH=2: ch0 step 2.0, ch1 constant 0.0 interleaved -> ch1 outputs all 0.0; ch0 ramps 0.5,1.0,1.5,2.0; out_ch tracks input.
REQ-035 DECIM=3, N_CH=1: 9 accepted samples -> exactly 3 strobes after samples 3,6,9; bypass=1 -> 9 strobes with out_sample = input.
REQ-036 OUT_LIMIT=1.0, coef all 1.0, input 0.5 constant -> outputs 0.5,1.0,1.0 (sat=0,0,1 at 1.5),1.0 sat=1; negative mirror -> -1.0 sat=1.
REQ-037 Write coef[0]=2.0 same cycle as sample 1.0 -> that result 0.25; next sample 1.0 -> 2.0+0.25 = 2.25.
REQ-038 Assert rst between clk edges mid-stream with in_valid pending -> out_valid low immediately, no strobe next edge; post-reset impulse reproduces REQ-033 sequence.
